// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: retire-trace record layout, HALT opcode and the
// output-slot state encoding used by the trace arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  regbits_t;

    localparam logic [5:0] HALT_OPCODE = 6'h3F;

    typedef struct packed {
        word_t      pc;
        word_t      instr;
        word_t      next_pc;
        word_t      reg_dat;
        word_t      dat_addr;
        word_t      store_dat;
        regbits_t   wsel;
        logic [1:0] cpuid;
    } trace_rec_t;

    typedef enum logic {
        SlotEmpty,
        SlotFull
    } slot_state_e;

    function automatic logic is_halt(input word_t instr, input logic [5:0] op);
        return instr[31:26] == op;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Per-core retire-record FIFO: circular buffer with one extra pointer bit so
// full and empty are told apart by the pointer MSBs.
module trace_fifo
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  trace_rec_t wdata_i,
    input  logic       pop_i,
    output trace_rec_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    trace_rec_t  mem_q [DEPTH];
    trace_rec_t  mem_d [DEPTH];

    logic full, empty, do_push, do_pop;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
            mem_d[wptr_q[AW-1:0]] = wdata_i;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: rtl/trace_arbiter.sv
// Round-robin merge of per-core retire-trace FIFOs into one registered output
// slot, with per-core retire counters, sticky HALT flags and a done flag.
module trace_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NCORES  = 2,
    parameter int unsigned DEPTH   = 4,
    parameter logic [5:0]  HALT_OP = HALT_OPCODE
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NCORES-1:0]        ret_valid,
    input  trace_rec_t [NCORES-1:0]  ret_rec,
    output logic [NCORES-1:0]        ret_ready,
    output logic                     out_valid,
    output trace_rec_t               out_rec,
    input  logic                     out_ready,
    output logic [NCORES-1:0]        halted,
    output logic [NCORES-1:0][31:0]  retire_cnt,
    output logic                     trace_done
);

    localparam int unsigned GW = (NCORES > 1) ? $clog2(NCORES) : 1;

    logic [NCORES-1:0] fifo_full, fifo_empty, fifo_pop;
    trace_rec_t        fifo_rdata [NCORES];

    for (genvar g = 0; g < NCORES; g++) begin : gen_fifo
        trace_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (CLK),
            .rst_i   (RST),
            .push_i  (ret_valid[g]),
            .wdata_i (ret_rec[g]),
            .pop_i   (fifo_pop[g]),
            .rdata_o (fifo_rdata[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );
    end

    slot_state_e             state_q, state_d;
    trace_rec_t              out_rec_q, out_rec_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [NCORES-1:0]       halted_q, halted_d;
    logic [NCORES-1:0][31:0] retire_cnt_q, retire_cnt_d;
    logic                    trace_done_q, trace_done_d;

    logic          load, found, fire;
    logic [GW-1:0] grant;
    int unsigned   idx;

    assign load = (state_q == SlotEmpty) || out_ready;
    assign fire = (state_q == SlotFull) && out_ready;

    // Search starts one past the last winner, so every core waits at most NCORES-1 grants.
    always_comb begin
        found = 1'b0;
        grant = last_grant_q;
        idx   = 0;
        for (int k = 1; k <= int'(NCORES); k++) begin
            idx = (32'(last_grant_q) + 32'(k)) % NCORES;
            if (!found && !fifo_empty[idx[GW-1:0]]) begin
                found = 1'b1;
                grant = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        for (int i = 0; i < int'(NCORES); i++) begin
            fifo_pop[i] = load && found && (grant == GW'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SlotEmpty: if (found) state_d = SlotFull;
            SlotFull:  if (out_ready && !found) state_d = SlotEmpty;
            default:   state_d = SlotEmpty;
        endcase
    end

    always_comb begin
        out_rec_d    = out_rec_q;
        last_grant_d = last_grant_q;
        if (load && found) begin
            out_rec_d       = fifo_rdata[grant];
            out_rec_d.cpuid = 2'(grant);
            last_grant_d    = grant;
        end
    end

    always_comb begin
        halted_d     = halted_q;
        retire_cnt_d = retire_cnt_q;
        for (int i = 0; i < int'(NCORES); i++) begin
            if (fire && (out_rec_q.cpuid == 2'(i))) begin
                retire_cnt_d[i] = retire_cnt_q[i] + 32'd1;
                if (is_halt(out_rec_q.instr, HALT_OP)) begin
                    halted_d[i] = 1'b1;
                end
            end
        end
        trace_done_d = trace_done_q
                     || ((&halted_q) && (&fifo_empty) && (state_q == SlotEmpty));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= SlotEmpty;
            out_rec_q    <= '0;
            last_grant_q <= GW'(NCORES - 1);
            halted_q     <= '0;
            retire_cnt_q <= '0;
            trace_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_rec_q    <= out_rec_d;
            last_grant_q <= last_grant_d;
            halted_q     <= halted_d;
            retire_cnt_q <= retire_cnt_d;
            trace_done_q <= trace_done_d;
        end
    end

    always_comb begin
        ret_ready  = ~fifo_full;
        out_valid  = (state_q == SlotFull);
        out_rec    = out_rec_q;
        halted     = halted_q;
        retire_cnt = retire_cnt_q;
        trace_done = trace_done_q;
    end

endmodule

// File: doc/trace_arbiter.md
Name: trace_arbiter

Overview:
- Shares the single retire-trace logging path between NCORES cores of the multicore build.
- Each core's writeback stage pushes one retired-instruction record per retire into a private FIFO.
- A round-robin arbiter drains the FIFOs through a registered output stage into the trace writer.
- Preserves per-core program order, tracks per-core HALT and retire counts, and raises trace_done when every core has halted and everything has drained.

Parameters:
- NCORES, 2, number of requesting cores (1..4).
- DEPTH, 4, entries per core FIFO (power of two, >=2).
- HALT_OP, 6'h3F, opcode value (instr[31:26]) that marks HALT.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ret_valid  in  NCORES  core i presents a retired record.
- ret_rec  in  NCORES x trace_rec_t  record per core.
- ret_ready  out  NCORES  FIFO i not full; record accepted when valid && ready.
- out_valid  out  1  out_rec holds a record.
- out_rec  out  trace_rec_t  arbitrated record; cpuid field is overwritten with the source index.
- out_ready  in  1  trace writer consumes out_rec this edge.
- halted  out  NCORES  sticky; core i's HALT record has been output.
- retire_cnt  out  NCORES x 32  records output per core, wraps at 2^32.
- trace_done  out  1  all halted, all FIFOs empty, out_valid low.

Behaviour:
- Reset values:
  - All FIFOs empty; ret_ready all 1.
  - out_valid 0; out_rec 0.
  - halted 0; retire_cnt 0; trace_done 0.
  - RR pointer set so core 0 wins first.
- Per-core FIFO:
  - Circular buffer, log2(DEPTH)+1-bit read/write pointers; full/empty derived from the pointer MSB.
  - ret_ready[i] = !full[i], combinational from registered state only.
  - Push and pop in the same cycle on a full FIFO is not allowed: ready is already low.
  - Push and pop on a non-full FIFO: count unchanged, both happen.
- Output stage:
  - One register slot. load = !out_valid || out_ready.
  - When load and any FIFO is non-empty, the grant picks the first non-empty core after last_grant in cyclic order. That FIFO pops, out_rec and out_valid are loaded, and last_grant is updated.
  - When load and all FIFOs are empty, out_valid goes to 0.
  - out_rec is held stable while out_valid && !out_ready.
- Latency: a record accepted at edge N appears on out_rec after edge N+1 at the earliest. There is no bypass.
- Throughput: 1 record/cycle aggregate. With all cores continuously busy, each core gets 1 of every NCORES slots.
- Fairness: a core waits at most NCORES-1 grants.
- Counters and flags, updated on the out_valid && out_ready edge for source core s:
  - retire_cnt[s] increments.
  - If out_rec.instr[31:26]==HALT_OP, halted[s] sets.
- trace_done is registered: it asserts the cycle after the condition holds and stays set until reset.
- Records arriving after halted[s] are still passed through; no special handling.
- RST asserted mid-operation clears everything immediately, including records in flight. Outputs return to reset values asynchronously.
- No FSM beyond the output slot's EMPTY/FULL states and last_grant. EMPTY->FULL on grant. FULL->EMPTY on out_ready with no requests. FULL->FULL on out_ready with a request (reload) or on !out_ready (hold).

Decomposition:
- cpu_types_pkg gains:
  - trace_rec_t packed struct: pc, instr, next_pc, reg_dat, dat_addr, store_dat (each word_t), wsel (regbits_t), cpuid (logic[1:0]); 200 bits.
  - HALT opcode constant reuse.
- Sub-module trace_fifo (parameter DEPTH, data type trace_rec_t), instantiated NCORES times.
- Arbiter, output slot and counters stay in trace_arbiter.

Test Plan:
- Reset, then core0 pushes one record pc=0x0 at edge 1 with out_ready=1 -> out_valid=1 after edge 2 with pc=0x0, cpuid=0; retire_cnt[0]=1 after edge 3.
- Both cores push every cycle for 8 cycles, out_ready=1 -> output alternates core0,core1,...; per-core pc order preserved; no record lost.
- out_ready=0 for 10 cycles while core1 pushes 6 records (DEPTH=4) -> ret_ready[1]=0 once FIFO holds 4 and the slot holds 1; out_rec stable. Release -> all 5 accepted records emerge in order.
- Core0 pushes HALT (instr=0xFC000000), core1 pushes 3 ALU records then HALT -> halted=01 then 11; trace_done rises 1 cycle after the last output with FIFOs empty.
- Assert RST with 3 records queued and out_valid=1 -> out_valid=0 immediately; ret_ready all 1; counters 0. Post-reset traffic behaves as in scenario 1.
- Preload retire_cnt[0]=0xFFFFFFFF via force, output one core0 record -> retire_cnt[0]=0.
